// File: rtl/xpu_vpu_pc_tn_vlsu_bf16_nan_canon.sv
// Streaming bf16 NaN canonicaliser for the VLSU store path: one register stage, per-lane NaN mask,
// saturating NaN counter. Define XPU_VPU_BF16_NAN_PAYLOAD_KEEP_EN to keep sign/payload (quiet bit forced).
module xpu_vpu_pc_tn_vlsu_bf16_nan_canon #(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [LANES*16-1:0]   in_data,
  input  logic [LANES-1:0]      in_mask,
  input  logic                  canon_en,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [LANES*16-1:0]   out_data,
  output logic [LANES-1:0]      out_nan_mask,
  output logic [CNT_W-1:0]      nan_cnt,
  input  logic                  nan_cnt_clr
);

  localparam int PC_W  = $clog2(LANES + 1);
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  logic                 out_vld_q, out_vld_d;
  logic [LANES*16-1:0]  out_data_q, out_data_d;
  logic [LANES-1:0]     out_nan_mask_q, out_nan_mask_d;
  logic [CNT_W-1:0]     nan_cnt_q, nan_cnt_d;

  logic                 accept;
  logic [LANES-1:0]     nan_lane;
  logic [LANES*16-1:0]  canon_data;
  logic [PC_W-1:0]      nan_pop;
  logic [SUM_W-1:0]     cnt_sum;

  assign in_rdy = !out_vld_q || out_rdy;
  assign accept = in_vld && in_rdy;

  // Per-lane classify and rewrite; inactive lanes are never flagged or modified.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    nan_lane   = '0;
    canon_data = in_data;
    nan_pop    = '0;
    for (int i = 0; i < LANES; i++) begin
      nan_lane[i] = in_mask[i] && (in_data[16*i+7 +: 8] == 8'hFF) && (in_data[16*i +: 7] != 7'd0);
      if (nan_lane[i] && canon_en) begin
`ifdef XPU_VPU_BF16_NAN_PAYLOAD_KEEP_EN
        canon_data[16*i +: 16] = {in_data[16*i+15], 8'hFF, 1'b1, in_data[16*i +: 6]};
`else
        canon_data[16*i +: 16] = 16'h7FC0;
`endif
      end
      nan_pop = nan_pop + PC_W'(nan_lane[i]);
    end
  end

  always_comb begin
    out_vld_d      = out_vld_q;
    out_data_d     = out_data_q;
    out_nan_mask_d = out_nan_mask_q;
    if (accept) begin
      out_vld_d      = 1'b1;
      out_data_d     = canon_data;
      out_nan_mask_d = nan_lane;
    end else if (out_rdy) begin
      out_vld_d      = 1'b0;
    end
  end

  // Clear takes priority over the running total but still counts the beat accepted with it.
  always_comb begin
    cnt_sum   = (nan_cnt_clr ? '0 : SUM_W'(nan_cnt_q)) + (accept ? SUM_W'(nan_pop) : '0);
    nan_cnt_d = nan_cnt_q;
    if (nan_cnt_clr || accept) begin
      nan_cnt_d = (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cnt_sum[CNT_W-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
  // The data register is reset as well, since out_data is defined as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q      <= 1'b0;
      out_data_q     <= '0;
      out_nan_mask_q <= '0;
      nan_cnt_q      <= '0;
    end else begin
      out_vld_q      <= out_vld_d;
      out_data_q     <= out_data_d;
      out_nan_mask_q <= out_nan_mask_d;
      nan_cnt_q      <= nan_cnt_d;
    end
  end

  assign out_vld      = out_vld_q;
  assign out_data     = out_data_q;
  assign out_nan_mask = out_nan_mask_q;
  assign nan_cnt      = nan_cnt_q;

endmodule

// File: tb/tb_xpu_vpu_pc_tn_vlsu_bf16_nan_canon.sv
// Self-checking bench for the bf16 NaN canonicaliser: directed and random beats against a
// spec-level reference model; a 4-bit counter makes saturation reachable.
module tb_xpu_vpu_pc_tn_vlsu_bf16_nan_canon;

  localparam int LANES = 4;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_vld = 1'b0;
  logic                 in_rdy;
  logic [LANES*16-1:0]  in_data = '0;
  logic [LANES-1:0]     in_mask = '0;
  logic                 canon_en = 1'b0;
  logic                 out_vld;
  logic                 out_rdy = 1'b0;
  logic [LANES*16-1:0]  out_data;
  logic [LANES-1:0]     out_nan_mask;
  logic [CNT_W-1:0]     nan_cnt;
  logic                 nan_cnt_clr = 1'b0;

  xpu_vpu_pc_tn_vlsu_bf16_nan_canon #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data), .in_mask(in_mask),
    .canon_en(canon_en),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_nan_mask(out_nan_mask),
    .nan_cnt(nan_cnt), .nan_cnt_clr(nan_cnt_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int delivered = 0;

  // Reference model state: the beat the output register should hold, and the counter value.
  logic                m_vld = 1'b0;
  logic [LANES*16-1:0] m_data = '0;
  logic [LANES-1:0]    m_mask = '0;
  int                  m_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_is_nan(input logic [15:0] h);
    int e, m;
    e = (int'(h) >> 7) & 255;
    m = int'(h) % 128;
    return (e == 255) && (m != 0);
  endfunction

  function automatic logic [15:0] ref_lane(input logic [15:0] h, input bit active, input bit ce);
    if (!(active && ce && ref_is_nan(h))) return h;
`ifdef XPU_VPU_BF16_NAN_PAYLOAD_KEEP_EN
    return h | 16'h0040;
`else
    return 16'h7FC0;
`endif
  endfunction

  function automatic logic [15:0] rand_lane();
    logic [15:0] h;
    h = 16'($urandom);
    case ($urandom_range(0, 3))
      0: h = {h[15], 8'hFF, 7'($urandom_range(1, 127))};
      1: h = {h[15], 8'hFF, 7'd0};
      default: ;
    endcase
    return h;
  endfunction

  // One clock of stimulus: drive, check in_rdy, step the edge, advance the model, check outputs.
  task automatic cycle(input bit vld, input logic [63:0] d, input logic [3:0] mk, input bit ce,
                       input bit ordy, input bit clr);
    bit acc;
    int pop;
    logic [63:0] nd;
    logic [3:0]  nm;
    in_vld = vld; in_data = d; in_mask = mk; canon_en = ce; out_rdy = ordy; nan_cnt_clr = clr;
    #1;
    check("in_rdy", in_rdy, (!m_vld || ordy));
    acc = vld && (!m_vld || ordy);
    if (m_vld && ordy) delivered++;
    pop = 0; nd = d; nm = '0;
    for (int i = 0; i < LANES; i++) begin
      nm[i] = mk[i] && ref_is_nan(d[16*i +: 16]);
      nd[16*i +: 16] = ref_lane(d[16*i +: 16], mk[i], ce);
      pop += int'(nm[i]);
    end
    @(posedge clk);
    if (acc) begin
      m_vld = 1'b1; m_data = nd; m_mask = nm;
    end else if (ordy) begin
      m_vld = 1'b0;
    end
    if (clr) m_cnt = acc ? pop : 0;
    else if (acc) m_cnt = m_cnt + pop;
    if (m_cnt > CNT_MAX) m_cnt = CNT_MAX;
    #1;
    check("out_vld", out_vld, m_vld);
    if (m_vld) begin
      check("out_data", out_data, m_data);
      check("out_nan_mask", out_nan_mask, m_mask);
    end
    check("nan_cnt", nan_cnt, m_cnt);
  endtask

  localparam logic [63:0] BEAT_A = {16'h7FC1, 16'h3F80, 16'h7F80, 16'hFF81};
  localparam logic [63:0] NAN4   = {16'h7FC1, 16'hFF81, 16'h7F81, 16'hFFFF};
  localparam logic [63:0] NAN3   = {16'h3F80, 16'hFF81, 16'h7F81, 16'hFFFF};
  localparam logic [63:0] NAN2   = {16'h3F80, 16'h7F80, 16'h7F81, 16'hFFFF};

  initial begin
    logic [63:0] rd;
    int sent;
    int guard;
    // Reset state
    #2;
    check("reset_out_vld", out_vld, 1'b0);
    check("reset_out_data", out_data, 64'd0);
    check("reset_nan_mask", out_nan_mask, 4'd0);
    check("reset_nan_cnt", nan_cnt, 4'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_rdy_after_reset", in_rdy, 1'b1);

    // Reference beat, full mask
    cycle(1, BEAT_A, 4'hF, 1, 0, 0);
`ifdef XPU_VPU_BF16_NAN_PAYLOAD_KEEP_EN
    check("beat_a_data", out_data, {16'h7FC1, 16'h3F80, 16'h7F80, 16'hFFC1});
`else
    check("beat_a_data", out_data, {16'h7FC0, 16'h3F80, 16'h7F80, 16'h7FC0});
`endif
    check("beat_a_mask", out_nan_mask, 4'b1001);
    check("beat_a_cnt", nan_cnt, 4'd2);

    // Inactive lane passes unchanged; canon_en=0 classifies only
    cycle(1, BEAT_A, 4'b1000, 1, 1, 0);
    check("masked_lane0", out_data[15:0], 16'hFF81);
    check("masked_mask", out_nan_mask, 4'b1000);
    check("masked_cnt", nan_cnt, 4'd3);
    cycle(1, BEAT_A, 4'hF, 0, 1, 0);
    check("passthru_data", out_data, BEAT_A);
    check("passthru_mask", out_nan_mask, 4'b1001);
    check("passthru_cnt", nan_cnt, 4'd5);

    // Mid-stream async reset with a held beat
    #2 rst_n = 1'b0;
    #1;
    check("midreset_out_vld", out_vld, 1'b0);
    check("midreset_nan_cnt", nan_cnt, 4'd0);
    m_vld = 1'b0; m_cnt = 0;
    #1 rst_n = 1'b1;
    out_rdy = 1'b0;
    #1;
    check("midreset_in_rdy", in_rdy, 1'b1);
    @(posedge clk); #1;

    // Saturation: clear, preload to 14, then a 3-NaN beat
    cycle(0, 64'd0, 4'h0, 1, 1, 1);
    for (int i = 0; i < 3; i++) cycle(1, NAN4, 4'hF, 1, 1, 0);
    cycle(1, NAN2, 4'hF, 1, 1, 0);
    check("preload_14", nan_cnt, 4'd14);
    cycle(1, NAN3, 4'hF, 1, 1, 0);
    check("saturate_15", nan_cnt, 4'd15);
    cycle(1, NAN4, 4'hF, 1, 1, 0);
    check("saturate_hold", nan_cnt, 4'd15);
    cycle(1, NAN2, 4'hF, 1, 1, 1);
    check("clr_with_accept", nan_cnt, 4'd2);
    cycle(0, 64'd0, 4'h0, 1, 1, 0);

    // Backpressure: 8 beats with out_rdy 1,0,0 repeating
    delivered = 0; sent = 0; guard = 0;
    while (sent < 8 && guard < 100) begin
      bit ordy;
      ordy = (guard % 3) == 0;
      for (int l = 0; l < LANES; l++) rd[16*l +: 16] = rand_lane();
      if (!m_vld || ordy) sent++;
      cycle(1, rd, 4'($urandom), 1'($urandom), ordy, 0);
      guard++;
    end
    check("bp_sent_in_budget", sent, 8);
    guard = 0;
    while (m_vld && guard < 10) begin
      cycle(0, 64'd0, 4'h0, 1, 1, 0);
      guard++;
    end
    check("bp_delivered", delivered, 8);

    // Back-to-back: 16 random beats at full rate
    delivered = 0;
    for (int n = 0; n < 16; n++) begin
      for (int l = 0; l < LANES; l++) rd[16*l +: 16] = rand_lane();
      cycle(1, rd, 4'($urandom), 1'($urandom), 1, 0);
      check("b2b_out_vld", out_vld, 1'b1);
    end
    cycle(0, 64'd0, 4'h0, 1, 1, 0);
    check("b2b_delivered", delivered, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
